// File: rtl/dual_rail_pkg.sv
// Shared constants and types for the dual-rail receive checker.
package dual_rail_pkg;

  // Encoding selectors, held as two ASCII characters
  localparam logic [15:0] ENC_TP = "TP";
  localparam logic [15:0] ENC_FP = "FP";

  // Per-bit rail codes: rail 1 carries logic 1, rail 0 carries logic 0
  localparam logic [1:0] SPACER  = 2'b00;
  localparam logic [1:0] ZERO    = 2'b01;
  localparam logic [1:0] ONE     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  // Four-phase protocol position
  typedef enum logic {
    S_SPACER = 1'b0,
    S_DATA   = 1'b1
  } fp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO holding decoded tokens.
// A push while full is accepted only when a pop frees a slot on the same edge;
// a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dual_rail_rx_checker.sv
// Dual-rail receiver: synchronises an asynchronous dual-rail bus, decodes
// two-phase or four-phase tokens, buffers them and flags protocol errors.
module dual_rail_rx_checker
  import dual_rail_pkg::*;
#(
  parameter logic [15:0] ENC         = ENC_TP,
  parameter int          WIDTH       = 8,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0][1:0] in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [31:0]           token_count,
  output logic                  err_illegal,
  output logic                  err_overflow,
  output logic                  err_pulse
);

  logic [WIDTH-1:0][1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0][1:0] sin;
  logic [WIDTH-1:0][1:0] ref_q;
  logic [WIDTH-1:0][1:0] ref_d;
  logic [WIDTH-1:0][1:0] code;
  logic [WIDTH-1:0]      word;
  fp_state_t             state_q;
  fp_state_t             state_d;
  logic                  all_complete;
  logic                  any_illegal;
  logic                  all_zero;
  logic                  push_req;
  logic                  illegal_evt;
  logic                  overflow_evt;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Per-rail synchroniser chain; only the last stage feeds the decoder
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sin      = sync_q[SYNC_STAGES-1];
  assign all_zero = (sin == '0);

  // Classify each bit: two-phase works on the change since the reference,
  // four-phase works on the raw levels
  always_comb begin
    code         = '0;
    word         = '0;
    all_complete = 1'b1;
    any_illegal  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      code[i] = (ENC == ENC_FP) ? sin[i] : (sin[i] ^ ref_q[i]);
      word[i] = code[i][1];
      if (code[i] == ILLEGAL) any_illegal = 1'b1;
      if ((code[i] != ZERO) && (code[i] != ONE)) all_complete = 1'b0;
    end
  end

  // Decoder next-state: reference update (two-phase) or spacer/data FSM (four-phase)
  always_comb begin
    push_req    = 1'b0;
    illegal_evt = 1'b0;
    state_d     = state_q;
    ref_d       = ref_q;
    if (ENC == ENC_FP) begin
      if (any_illegal) begin
        illegal_evt = 1'b1;
        state_d     = S_SPACER;
      end else begin
        case (state_q)
          S_SPACER: if (all_zero) state_d = S_DATA;
          S_DATA: begin
            if (all_complete) begin
              push_req = 1'b1;
              state_d  = S_SPACER;
            end
          end
          default: state_d = S_SPACER;
        endcase
      end
    end else begin
      if (any_illegal) begin
        illegal_evt = 1'b1;
        ref_d       = sin;
      end else if (all_complete) begin
        push_req = 1'b1;
        ref_d    = sin;
      end
    end
  end

  // Decoder state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SPACER;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
    end
  end

  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  assign overflow_evt = push_req && fifo_full && !pop;

  sync_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (out_data)
  );

  // Token counter, sticky error flags and one-cycle error strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      token_count  <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      if (push_req && !overflow_evt) token_count <= token_count + 32'd1;
      if (illegal_evt)  err_illegal  <= 1'b1;
      if (overflow_evt) err_overflow <= 1'b1;
      err_pulse <= illegal_evt | overflow_evt;
    end
  end

endmodule

// File: tb/tb_dual_rail_rx_checker.sv
// Self-checking bench: one two-phase and one four-phase instance, checked
// against a token-queue model driven by the stimulus tasks.
module tb_dual_rail_rx_checker;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  localparam int K_TOKEN   = 0;
  localparam int K_ILLEGAL = 1;
  localparam int K_SPACER  = 2;
  localparam int K_PARTIAL = 3;

  typedef struct {
    int           due;
    bit           ill;
    logic [W-1:0] v;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                out_ready = 1'b0;
  logic [W-1:0][1:0]   bus_tp = '0;
  logic [W-1:0][1:0]   bus_fp = '0;

  logic                tp_valid, fp_valid;
  logic [W-1:0]        tp_data, fp_data;
  logic [31:0]         tp_count, fp_count;
  logic                tp_ill, fp_ill, tp_ovf, fp_ovf, tp_pulse, fp_pulse;

  logic                obs_valid, obs_ill, obs_ovf, obs_pulse;
  logic [W-1:0]        obs_data;
  logic [31:0]         obs_count;

  bit                  sel_fp = 1'b0;
  bit                  mon_en = 1'b0;
  int                  ready_mode = 1;
  int                  cyc = 0;
  int                  checks = 0;
  int                  failures = 0;

  ev_t                 pend[$];
  logic [W-1:0]        mq[$];
  int                  exp_count = 0;
  bit                  exp_ill = 1'b0;
  bit                  exp_ovf = 1'b0;
  bit                  exp_pulse = 1'b0;
  bit                  fp_armed = 1'b0;

  dual_rail_rx_checker #(
    .ENC("TP"), .WIDTH(W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) u_tp (
    .clk(clk), .rst(rst), .in(bus_tp), .out_valid(tp_valid), .out_ready(out_ready),
    .out_data(tp_data), .token_count(tp_count), .err_illegal(tp_ill),
    .err_overflow(tp_ovf), .err_pulse(tp_pulse)
  );

  dual_rail_rx_checker #(
    .ENC("FP"), .WIDTH(W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) u_fp (
    .clk(clk), .rst(rst), .in(bus_fp), .out_valid(fp_valid), .out_ready(out_ready),
    .out_data(fp_data), .token_count(fp_count), .err_illegal(fp_ill),
    .err_overflow(fp_ovf), .err_pulse(fp_pulse)
  );

  assign obs_valid = sel_fp ? fp_valid : tp_valid;
  assign obs_data  = sel_fp ? fp_data  : tp_data;
  assign obs_count = sel_fp ? fp_count : tp_count;
  assign obs_ill   = sel_fp ? fp_ill   : tp_ill;
  assign obs_ovf   = sel_fp ? fp_ovf   : tp_ovf;
  assign obs_pulse = sel_fp ? fp_pulse : tp_pulse;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Consumer handshake: fixed low, fixed high, or random
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 99) < 35);
    endcase
  end

  // Reference model: scheduled decode events feed a bounded token queue
  always @(posedge clk) begin : model
    bit           pop_m, push_m, ill_m, ovf_m;
    logic [W-1:0] pv;
    ev_t          keep[$];
    cyc++;
    if (rst) begin
      mq.delete();
      pend.delete();
      exp_count = 0;
      exp_ill   = 1'b0;
      exp_ovf   = 1'b0;
      exp_pulse = 1'b0;
    end else begin
      pop_m  = out_ready && (mq.size() > 0);
      push_m = 1'b0;
      ill_m  = 1'b0;
      pv     = '0;
      keep.delete();
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          if (pend[i].ill) ill_m = 1'b1;
          else begin
            push_m = 1'b1;
            pv     = pend[i].v;
          end
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend  = keep;
      ovf_m = push_m && (mq.size() == DEPTH) && !pop_m;
      if (pop_m) void'(mq.pop_front());
      if (push_m && !ovf_m) begin
        mq.push_back(pv);
        exp_count++;
      end
      exp_pulse = ill_m || ovf_m;
      if (ill_m) exp_ill = 1'b1;
      if (ovf_m) exp_ovf = 1'b1;
    end
  end

  // Every cycle compare the selected instance against the model
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("out_valid", 32'(obs_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) checkOutput("out_data", 32'(obs_data), 32'(mq[0]));
      checkOutput("token_count", obs_count, 32'(exp_count));
      checkOutput("err_illegal", 32'(obs_ill), 32'(exp_ill));
      checkOutput("err_overflow", 32'(obs_ovf), 32'(exp_ovf));
      checkOutput("err_pulse", 32'(obs_pulse), 32'(exp_pulse));
    end
  end

  task automatic driveBus(input logic [W-1:0][1:0] x);
    if (sel_fp) bus_fp = x;
    else        bus_tp = x;
  endtask

  // Drive one bus event; a token is expected SYNC+1 edges after the final change
  task automatic applyStimulus(input int kind, input logic [W-1:0] v, input int bitsel,
                               input bit split, input int hold);
    logic [W-1:0][1:0] cur, nxt, mid;
    logic [W-1:0]      first;
    ev_t               e;
    cur = sel_fp ? bus_fp : bus_tp;
    nxt = cur;
    case (kind)
      K_TOKEN: begin
        for (int i = 0; i < W; i++) begin
          if (sel_fp) nxt[i] = v[i] ? 2'b10 : 2'b01;
          else        nxt[i][v[i]] = ~nxt[i][v[i]];
        end
      end
      K_ILLEGAL: nxt[bitsel] = nxt[bitsel] ^ 2'b11;
      K_SPACER:  nxt = '0;
      default: begin
        for (int i = 0; i < W; i++) nxt[i] = (i < bitsel) ? (v[i] ? 2'b10 : 2'b01) : 2'b00;
      end
    endcase
    if (split && (kind == K_TOKEN)) begin
      first = W'($urandom);
      first[W-1] = 1'b0;
      for (int i = 0; i < W; i++) mid[i] = first[i] ? nxt[i] : cur[i];
      driveBus(mid);
      waitCycles($urandom_range(1, 3));
    end
    driveBus(nxt);
    e.due = cyc + 1 + SYNC;
    e.v   = v;
    e.ill = (kind == K_ILLEGAL);
    if (kind == K_ILLEGAL) pend.push_back(e);
    if (kind == K_TOKEN && (!sel_fp || fp_armed)) begin
      pend.push_back(e);
      fp_armed = 1'b0;
    end
    waitCycles(hold);
    if (kind == K_SPACER) fp_armed = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    checkOutput("rst_out_valid", 32'(obs_valid), 32'd0);
    checkOutput("rst_token_count", obs_count, 32'd0);
    checkOutput("rst_err_illegal", 32'(obs_ill), 32'd0);
    checkOutput("rst_err_overflow", 32'(obs_ovf), 32'd0);
    checkOutput("rst_err_pulse", 32'(obs_pulse), 32'd0);
    rst = 1'b0;
    waitCycles(3);

    // Two-phase token 4'hA: valid exactly on the third edge after the change
    applyStimulus(K_TOKEN, 4'hA, 0, 1'b0, 0);
    @(negedge clk); checkOutput("tpA_edge1_valid", 32'(tp_valid), 32'd0);
    @(negedge clk); checkOutput("tpA_edge2_valid", 32'(tp_valid), 32'd0);
    @(negedge clk);
    checkOutput("tpA_edge3_valid", 32'(tp_valid), 32'd1);
    checkOutput("tpA_data", 32'(tp_data), 32'hA);
    checkOutput("tpA_count", tp_count, 32'd1);
    @(negedge clk); checkOutput("tpA_edge4_valid", 32'(tp_valid), 32'd0);
    waitCycles(2);

    // Both rails of bit 2 toggle: illegal, no token; next token still decodes
    applyStimulus(K_ILLEGAL, '0, 2, 1'b0, SYNC + 2);
    checkOutput("tp_illegal_flag", 32'(tp_ill), 32'd1);
    checkOutput("tp_illegal_count", tp_count, 32'd1);
    applyStimulus(K_TOKEN, 4'h5, 0, 1'b0, SYNC + 2);
    checkOutput("tp_after_illegal_count", tp_count, 32'd2);

    // Five tokens with the consumer stalled: four kept, one dropped
    ready_mode = 0;
    waitCycles(2);
    for (int t = 1; t <= 5; t++) applyStimulus(K_TOKEN, W'(t), 0, 1'b0, SYNC + 2);
    checkOutput("ovf_count", tp_count, 32'd6);
    checkOutput("ovf_flag", 32'(tp_ovf), 32'd1);
    checkOutput("ovf_valid", 32'(tp_valid), 32'd1);
    ready_mode = 1;
    waitCycles(8);
    checkOutput("drain_valid", 32'(tp_valid), 32'd0);

    // Random two-phase traffic with a random consumer
    ready_mode = 2;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 9) == 0)
        applyStimulus(K_ILLEGAL, '0, $urandom_range(0, W - 1), 1'b0, SYNC + 2);
      else
        applyStimulus(K_TOKEN, W'($urandom), 0, 1'($urandom_range(0, 1)), SYNC + 2);
    end
    ready_mode = 1;
    waitCycles(8);

    // Switch to the four-phase instance
    mon_en = 1'b0;
    sel_fp = 1'b1;
    rst    = 1'b1;
    waitCycles(3);
    mon_en = 1'b1;
    checkOutput("fp_rst_count", fp_count, 32'd0);
    rst      = 1'b0;
    fp_armed = 1'b0;
    waitCycles(2);

    // Token 7, then new data without a spacer must not produce a token
    applyStimulus(K_SPACER, '0, 0, 1'b0, SYNC + 2);
    applyStimulus(K_TOKEN, 4'h7, 0, 1'b0, SYNC + 2);
    checkOutput("fp_tok7_count", fp_count, 32'd1);
    applyStimulus(K_TOKEN, 4'h9, 0, 1'b0, SYNC + 2);
    checkOutput("fp_nospacer_count", fp_count, 32'd1);
    applyStimulus(K_SPACER, '0, 0, 1'b0, SYNC + 2);
    applyStimulus(K_TOKEN, 4'h9, 0, 1'b0, SYNC + 2);
    checkOutput("fp_tok9_count", fp_count, 32'd2);

    // Reset with two tokens buffered and a partial word on the bus
    ready_mode = 0;
    applyStimulus(K_SPACER, '0, 0, 1'b0, SYNC + 2);
    applyStimulus(K_TOKEN, 4'h3, 0, 1'b0, SYNC + 2);
    applyStimulus(K_SPACER, '0, 0, 1'b0, SYNC + 2);
    applyStimulus(K_TOKEN, 4'hC, 0, 1'b0, SYNC + 2);
    applyStimulus(K_SPACER, '0, 0, 1'b0, SYNC + 2);
    applyStimulus(K_PARTIAL, 4'hF, 2, 1'b0, SYNC + 2);
    checkOutput("fp_partial_count", fp_count, 32'd4);
    checkOutput("fp_partial_ill", 32'(fp_ill), 32'd0);
    rst = 1'b1;
    waitCycles(2);
    checkOutput("fp_midrst_valid", 32'(fp_valid), 32'd0);
    checkOutput("fp_midrst_count", fp_count, 32'd0);
    rst        = 1'b0;
    fp_armed   = 1'b0;
    ready_mode = 1;
    applyStimulus(K_SPACER, '0, 0, 1'b0, SYNC + 2);
    applyStimulus(K_TOKEN, 4'h6, 0, 1'b0, SYNC + 2);
    checkOutput("fp_postrst_count", fp_count, 32'd1);

    // Random four-phase traffic, spacers usually but not always present
    ready_mode = 2;
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 4) != 0) applyStimulus(K_SPACER, '0, 0, 1'b0, SYNC + 2);
      applyStimulus(K_TOKEN, W'($urandom), 0, 1'($urandom_range(0, 1)), SYNC + 2);
    end
    ready_mode = 1;
    waitCycles(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_rail_rx_checker.md
DUAL_RAIL_RX_CHECKER -- requirements
Module: dual_rail_rx_checker

Interface
REQ-001 Parameter ENC, default "TP", selects the encoding: "TP" is two-phase transition, "FP" is four-phase return-to-zero.
REQ-002 Parameter WIDTH, default 8, is the number of dual-rail bits per token.
REQ-003 Parameter FIFO_DEPTH, default 4, is the decoded-token buffer depth; it SHALL be a power of two and at least 2.
REQ-004 Parameter SYNC_STAGES, default 2, is the synchroniser depth per rail; it SHALL be at least 2.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port in, input, [WIDTH-1:0][1:0]: asynchronous dual-rail bus; rail 1 means logic 1, rail 0 means logic 0.
REQ-008 Port out_valid, output, 1 bit: a decoded token is available.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the token when out_valid and out_ready are both high.
REQ-010 Port out_data, output, [WIDTH-1:0]: the decoded token value.
REQ-011 Port token_count, output, 32 bits: number of tokens written to the FIFO; wraps modulo 2^32.
REQ-012 Port err_illegal, output, 1 bit: sticky; an illegal rail code was seen.
REQ-013 Port err_overflow, output, 1 bit: sticky; a token was dropped because the FIFO was full.
REQ-014 Port err_pulse, output, 1 bit: single-cycle strobe on each new error event.

Function
REQ-015 Each rail of in SHALL pass through SYNC_STAGES flops; all decoding SHALL use only the last stage (sin).
REQ-016 TP: a reference register ref [WIDTH-1:0][1:0] holds the last accepted bus value; per bit, d = sin ^ ref.
REQ-017 TP: a bit is complete when d is 01 or 10; its value is 1 when d is 10 and 0 when d is 01.
REQ-018 TP: when all bits are complete, the decoded word SHALL be pushed and ref loaded with sin on the same edge.
REQ-019 TP: d equal to 11 on any bit is illegal; ref SHALL be loaded with sin, no token is pushed, and err_illegal and err_pulse are raised.
REQ-020 FP: the FSM has two states, S_DATA and S_SPACER, and resets to S_SPACER.
REQ-021 FP, S_SPACER: the FSM moves to S_DATA when sin is all zero.
REQ-022 FP, S_DATA: when every bit is 01 or 10, the word (value = rail 1) is pushed and the FSM moves to S_SPACER.
REQ-023 FP: any bit at 11 in either state is illegal; no push occurs, the error flags are raised, and the FSM is forced to S_SPACER.
REQ-024 An incomplete word (some bits still at the spacer/reference value) SHALL never push, and a partially complete word SHALL NOT be flagged as an error.
REQ-025 Latency: if edge N first samples a complete, stable input into sync stage 1, the push occurs on edge N+SYNC_STAGES and out_valid is high after that same edge.
REQ-026 The FIFO is show-ahead: out_data is valid whenever out_valid is high and SHALL be held stable until the token is accepted.
REQ-027 Push while full without a pop in the same cycle: the token is dropped, err_overflow and err_pulse are raised, and token_count is not incremented.
REQ-028 Push while full with a pop in the same cycle: the push is accepted.
REQ-029 Push and pop on an empty FIFO: the token is written, and the pop has no effect that cycle.
REQ-030 Pop while empty is ignored.
REQ-031 An illegal code and an overflow cannot coincide, since an illegal word never pushes; err_pulse is at most one cycle per event.

Reset
REQ-032 On rst: sync flops, ref, and FIFO pointers and count clear to 0; the FP FSM goes to S_SPACER; out_valid, token_count, err_illegal, err_overflow and err_pulse all go to 0.
REQ-033 Reset asserted mid-token discards any partial or buffered tokens; decoding resumes from the current bus value (TP ref = 0 after reset) or from the next spacer (FP).

Structure
REQ-034 Package dual_rail_pkg SHALL hold the encoding constants ENC_TP and ENC_FP, the FSM state enum, and the rail-code constants (SPACER = 2'b00, ZERO = 2'b01, ONE = 2'b10, ILLEGAL = 2'b11).
REQ-035 The token buffer SHALL be a separate sub-module named sync_fifo, parameterised by WIDTH and FIFO_DEPTH, with push, pop, full, empty and dout ports.

Verification
REQ-036 TP, WIDTH=4, out_ready=1: toggle rails giving d = {10,01,10,01} -> out_data=4'hA, token_count=1, out_valid high for 1 cycle, 3 edges after the change.
REQ-037 FP: drive data {01,10,10,10} -> token 4'h7; drive the next data without an intervening spacer -> no second token until all-zero is seen.
REQ-038 TP: toggle both rails of bit 2 -> err_illegal=1, err_pulse for 1 cycle, no token; the next legal token then decodes correctly.
REQ-039 FIFO_DEPTH=4, out_ready=0, 5 tokens -> 4 buffered, err_overflow=1, token_count=4; then out_ready=1 -> the 4 tokens drain in order.
REQ-040 Assert rst with 2 tokens buffered and a partial FP word on the bus -> out_valid=0 and counters=0; after a spacer, the next word decodes.
